mc_ctrl_fsm: RTL and testbench

- Main control unit for the multi-cycle MIPS core. Decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives every datapath strobe, and drives the 4-bit ALUOp code that the ALU-control decoder consumes.
- This block is the producer side of the ALUOp interface. It also applies a ready/hold handshake to instruction and data memory.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_ctrl_fsm_alu_op_enc.sv | 18 +
 rtl/mc_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control unit:
// opcodes, ALUOp codes, FSM state encoding and the strobe bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
  localparam logic [3:0] ALUOP_BNE   = 4'b0101;
  localparam logic [3:0] ALUOP_ADDI  = 4'b1000;
  localparam logic [3:0] ALUOP_SLTI  = 4'b1010;
  localparam logic [3:0] ALUOP_SLTIU = 4'b1011;
  localparam logic [3:0] ALUOP_ANDI  = 4'b1100;
  localparam logic [3:0] ALUOP_ORI   = 4'b1101;
  localparam logic [3:0] ALUOP_XORI  = 4'b1110;
  localparam logic [3:0] ALUOP_R     = 4'b1111;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_R_EXEC   = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_I_EXEC   = 4'd10;
  localparam logic [3:0] ST_I_WB     = 4'd11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
           (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_XORI);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || is_imm_op(op);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_op_enc.sv
// Opcode to ALUOp mapping: R-type gets the funct-decode code, branches and
// immediates pass their low opcode nibble through, everything else adds.
module alu_op_enc
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALUOP_ADD;
    if (opcode == OP_RTYPE)
      alu_op = ALUOP_R;
    else if (is_imm_op(opcode) || (opcode == OP_BEQ) || (opcode == OP_BNE))
      alu_op = opcode[3:0];
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, with a mem_ready hold on every memory access.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [1:0]       pc_source,
  output logic [3:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_o
);

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [3:0]       enc_alu_op;
  logic [CNT_W-1:0] cnt;
  ctrl_t            c;
  ctrl_t            o;

  alu_op_enc u_alu_op_enc (
    .opcode (opcode),
    .alu_op (enc_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (c.instr_done) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_FETCH:    next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode == OP_RTYPE)                         next_state = ST_R_EXEC;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) next_state = ST_MEM_ADDR;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) next_state = ST_BRANCH;
        else if (opcode == OP_J)                        next_state = ST_JUMP;
        else if (is_imm_op(opcode))                     next_state = ST_I_EXEC;
        else                                            next_state = ST_FETCH;
      end
      ST_MEM_ADDR: next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WR:   next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:   next_state = ST_R_WB;
      ST_I_EXEC:   next_state = ST_I_WB;
      default:     next_state = ST_FETCH;
    endcase
  end

  // Strobes are Moore except the FETCH loads and the MEM_WR retire, which wait on mem_ready.
  always_comb begin
    c = '0;
    case (state)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        c.alu_src_b  = 2'b11;
        c.illegal_op = !is_legal_op(opcode);
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_R;
      end
      ST_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = enc_alu_op;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_ne     = opcode[0];
        c.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_zero  = (opcode[3:2] == 2'b11);
        c.alu_op    = enc_alu_op;
      end
      ST_I_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // Reset holds the state at FETCH, so its strobes must be masked explicitly.
  assign o = rst_n ? c : '0;

  assign pc_write      = o.pc_write;
  assign pc_write_cond = o.pc_write_cond;
  assign branch_ne     = o.branch_ne;
  assign iord          = o.iord;
  assign mem_read      = o.mem_read;
  assign mem_write     = o.mem_write;
  assign ir_write      = o.ir_write;
  assign mem_to_reg    = o.mem_to_reg;
  assign reg_dst       = o.reg_dst;
  assign reg_write     = o.reg_write;
  assign alu_src_a     = o.alu_src_a;
  assign alu_src_b     = o.alu_src_b;
  assign ext_zero      = o.ext_zero;
  assign pc_source     = o.pc_source;
  assign alu_op        = o.alu_op;
  assign instr_done    = o.instr_done;
  assign illegal_op    = o.illegal_op;
  assign instr_cnt     = cnt;
  assign state_o       = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a cycle model queues the expected state,
// strobes and retire count per cycle; the drain loop drives and compares.
module tb_mc_ctrl_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero;
  logic [1:0]    alu_src_b, pc_source;
  logic [3:0]    alu_op;
  logic          instr_done, illegal_op;
  logic [CW-1:0] instr_cnt;
  logic [3:0]    state_o;

  mc_ctrl_fsm #(.CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_source(pc_source), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_cnt(instr_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [3:0]  st;
    logic [21:0] vec;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mcnt = 0;
  int          irw_seen;

  wire [21:0] dut_vec = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                         ext_zero, pc_source, alu_op, instr_done, illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr);
    logic pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa, ez, done, ill;
    logic [1:0] asb, psrc;
    logic [3:0] aop;
    logic legal;
    {pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa, ez, done, ill} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 4'b0000;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) ||
            (op == 6'h05) || (op == 6'h02) || (op == 6'h08) || (op == 6'h0a) ||
            (op == 6'h0b) || (op == 6'h0c) || (op == 6'h0d) || (op == 6'h0e);
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin asb = 2'b11; ill = !legal; end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin io = 1; mrd = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin io = 1; mwr = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 4'b1111; end
      4'd7:  begin rw = 1; rdst = 1; done = 1; end
      4'd8:  begin asa = 1; aop = op[3:0]; pwc = 1; psrc = 2'b01; bne = op[0]; done = 1; end
      4'd9:  begin pw = 1; psrc = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; ez = (op[3:2] == 2'b11); aop = op[3:0]; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, ez, psrc, aop, done, ill};
  endfunction

  function automatic logic [3:0] exp_next(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr);
    case (st)
      4'd0: return mr ? 4'd1 : 4'd0;
      4'd1: case (op)
              6'h00:                                     return 4'd6;
              6'h23, 6'h2b:                              return 4'd2;
              6'h04, 6'h05:                              return 4'd8;
              6'h02:                                     return 4'd9;
              6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: return 4'd10;
              default:                                   return 4'd0;
            endcase
      4'd2:  return (op == 6'h23) ? 4'd3 : 4'd5;
      4'd3:  return mr ? 4'd4 : 4'd3;
      4'd5:  return mr ? 4'd0 : 4'd5;
      4'd6:  return 4'd7;
      4'd10: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  // Push one instruction's expected cycles, then drive and compare them.
  task automatic run_instr(input string tag, input logic [5:0] op, input int fs, input int ms);
    exp_t r;
    logic [3:0] st = 4'd0;
    logic [3:0] nx;
    bit   left_fetch = 0;
    int   f = fs, m = ms;
    opcode = op;
    for (int i = 0; i < 64; i++) begin
      if (st == 4'd0)                     r.mr = (f > 0) ? 1'b0 : 1'b1;
      else if (st == 4'd3 || st == 4'd5)  r.mr = (m > 0) ? 1'b0 : 1'b1;
      else                                r.mr = 1'($urandom_range(0, 1));
      if (!r.mr && st == 4'd0) f--;
      if (!r.mr && (st == 4'd3 || st == 4'd5)) m--;
      r.st  = st;
      r.vec = exp_vec(st, op, r.mr);
      r.cnt = mcnt;
      sb.push_back(r);
      if (r.vec[1]) mcnt++;
      nx = exp_next(st, op, r.mr);
      if (st != 4'd0) left_fetch = 1;
      st = nx;
      if (left_fetch && st == 4'd0) break;
    end
    irw_seen = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr;
      @(negedge clk);
      chk({tag, "_state"}, 32'(state_o), 32'(r.st));
      chk({tag, "_ctrl"}, 32'(dut_vec), 32'(r.vec));
      chk({tag, "_cnt"}, 32'(instr_cnt), 32'(r.cnt[CW-1:0]));
      if (ir_write) irw_seen++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctrl", 32'(dut_vec), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr("rtype", 6'h00, 0, 0);

    // Abandon an LW in MEM_RD by asserting reset between edges.
    opcode = 6'h23; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_state", 32'(state_o), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_ctrl", 32'(dut_vec), 32'd0);
    chk("midrst_cnt", 32'(instr_cnt), 32'd0);
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_mem_read", 32'(mem_read), 32'd1);
    chk("post_rst_state", 32'(state_o), 32'd0);
    @(posedge clk); #1;

    run_instr("lw", 6'h23, 2, 3);
    chk("lw_ir_write_pulses", 32'(irw_seen), 32'd1);
    run_instr("bne", 6'h05, 0, 0);
    run_instr("beq", 6'h04, 1, 0);
    run_instr("ori", 6'h0d, 0, 0);
    run_instr("slti", 6'h0a, 0, 0);
    run_instr("sw", 6'h2b, 1, 2);
    run_instr("rtype2", 6'h00, 0, 0);
    run_instr("illegal", 6'h3f, 0, 0);
    run_instr("illegal2", 6'h01, 1, 0);
    while (mcnt < 32'd16) run_instr("j", 6'h02, 0, 0);
    @(negedge clk);
    chk("wrap_cnt", 32'(instr_cnt), 32'(mcnt[CW-1:0]));
    chk("wrap_state", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
